// File: rtl/cmp_bist_seq.sv
// Built-in self test sequencer for an external WIDTH-bit equality comparator.
// Optional first-failure capture is enabled by defining CMP_BIST_FAIL_CAPTURE_EN.
module cmp_bist_seq #(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic               eq_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt
`ifdef CMP_BIST_FAIL_CAPTURE_EN
  ,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
`endif
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   settleCnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            busy_q, done_q, pass_q;
  logic [IW:0]     errCnt_q, errCnt_d;
  logic            mismatch;
  logic            lastVec;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
  logic            failValid_q;
  logic [WIDTH-1:0] failA_q, failB_q;
`endif

  // An unknown eq_i fails the equality test and therefore counts as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (eq_i == (a_q == b_q)) mismatch = 1'b0;
    errCnt_d = errCnt_q + {{IW{1'b0}}, mismatch};
    lastVec  = &idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      settleCnt_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCnt_q    <= '0;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
      failValid_q <= 1'b0;
      failA_q     <= '0;
      failB_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= DRIVE;
            idx_q    <= '0;
            errCnt_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
            failValid_q <= 1'b0;
            failA_q     <= '0;
            failB_q     <= '0;
`endif
          end
        end
        DRIVE: begin
          a_q         <= idx_q[IW-1:WIDTH];
          b_q         <= idx_q[WIDTH-1:0];
          settleCnt_q <= '0;
          state_q     <= (SETTLE_CYCLES > 1) ? SETTLE : CHECK;
        end
        SETTLE: begin
          if (int'(settleCnt_q) >= SETTLE_CYCLES - 2) state_q <= CHECK;
          else settleCnt_q <= settleCnt_q + 1'b1;
        end
        CHECK: begin
          errCnt_q <= errCnt_d;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
          if (mismatch && !failValid_q) begin
            failValid_q <= 1'b1;
            failA_q     <= a_q;
            failB_q     <= b_q;
          end
`endif
          if (lastVec) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCnt_d == '0);
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = errCnt_q;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
  assign fail_valid = failValid_q;
  assign fail_a     = failA_q;
  assign fail_b     = failB_q;
`endif

endmodule

// File: tb/tb_cmp_bist_seq.sv
// Self-checking bench for cmp_bist_seq: emulates good and faulty comparators
// and checks run timing and results against a vector-level reference model.
module tb_cmp_bist_seq;

   localparam int W  = 2;
   localparam int S  = 4;
   localparam int NV = 1 << (2 * W);

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [W-1:0]   aO, bO;
   logic           eqI;
   logic           busy, done, pass;
   logic [2*W:0]   errCnt;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
   logic           failValid;
   logic [W-1:0]   failA, failB;
`endif

   int             curMode;
   logic [NV-1:0]  flipMask;
   int             checkCount = 0;
   int             passCount  = 0;

   cmp_bist_seq #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .a_o(aO),
      .b_o(bO),
      .eq_i(eqI),
      .busy(busy),
      .done(done),
      .pass(pass),
      .err_cnt(errCnt)
`ifdef CMP_BIST_FAIL_CAPTURE_EN
      ,
      .fail_valid(failValid),
      .fail_a(failA),
      .fail_b(failB)
`endif
   );

   always #5 clk = ~clk;

   // Comparator under test: ideal, stuck-at, inverted, or randomly faulty per vector
   always_comb begin
      eqI = (aO == bO);
      case (curMode)
         1: eqI = 1'b0;
         2: eqI = 1'b1;
         3: eqI = !(aO == bO);
         4: eqI = (aO == bO) ^ flipMask[{aO, bO}];
         default: eqI = (aO == bO);
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Walks every operand pair the way the exerciser should and tallies what a
   // correct exerciser would report for the chosen comparator behaviour.
   task automatic computeRef(input int mode, output int errs, output int firstA, output int firstB);
      int a, b, ideal, obs;
      errs = 0; firstA = 0; firstB = 0;
      for (int v = 0; v < NV; v++) begin
         a = v / (1 << W);
         b = v % (1 << W);
         ideal = (a == b) ? 1 : 0;
         case (mode)
            1: obs = 0;
            2: obs = 1;
            3: obs = 1 - ideal;
            4: obs = ideal ^ int'(flipMask[v]);
            default: obs = ideal;
         endcase
         if (obs != ideal) begin
            if (errs == 0) begin firstA = a; firstB = b; end
            errs++;
         end
      end
   endtask

   task automatic applyStimulus(input int mode, input int glitchA, input int glitchB, input int abortAt);
      int cycles, expErr, expFa, expFb, busyDrops;
      bit finished;
      curMode = mode;
      computeRef(mode, expErr, expFa, expFb);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_clear", 32'({done, pass, errCnt}), 32'd0);
      cycles = 0; finished = 1'b0; busyDrops = 0;
      while (!finished && cycles < 1000) begin
         @(posedge clk); #1;
         cycles++;
         start = 1'b0;
         if (abortAt > 0 && cycles == abortAt) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            checkOutput("abort_zero", 32'({aO, bO, busy, done, pass, errCnt}), 32'd0);
            return;
         end
         if (done) finished = 1'b1;
         else begin
            if (!busy) busyDrops++;
            if (cycles == glitchA || cycles == glitchB) start = 1'b1;
         end
      end
      checkOutput("done_seen", 32'(finished), 32'd1);
      checkOutput("run_cycles", 32'(cycles), 32'(NV * (S + 1)));
      checkOutput("busy_held", 32'(busyDrops), 32'd0);
      checkOutput("busy_end", 32'(busy), 32'd0);
      checkOutput("err_cnt", 32'(errCnt), 32'(expErr));
      checkOutput("pass", 32'(pass), (expErr == 0) ? 32'd1 : 32'd0);
      checkOutput("last_vec", 32'({aO, bO}), 32'(NV - 1));
`ifdef CMP_BIST_FAIL_CAPTURE_EN
      checkOutput("fail_valid", 32'(failValid), (expErr != 0) ? 32'd1 : 32'd0);
      checkOutput("fail_ab", 32'({failA, failB}), 32'((expFa << W) | expFb));
`endif
      @(posedge clk); #1;
      checkOutput("done_hold", 32'({done, pass}), (expErr == 0) ? 32'd3 : 32'd2);
   endtask

   initial begin
      curMode = 0; flipMask = '0;
      reset = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", 32'({aO, bO, busy, done, pass, errCnt}), 32'd0);

      // Reset and start together: reset must win
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_wins", 32'(busy), 32'd0);
      reset = 1'b0; start = 1'b0;

      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("stuck0_cnt", 32'(errCnt), 32'd4);
      applyStimulus(2, 0, 0, 0);
      checkOutput("stuck1_cnt", 32'(errCnt), 32'd12);
      applyStimulus(3, 0, 0, 0);
      checkOutput("invert_cnt", 32'(errCnt), 32'd16);

      applyStimulus(0, 0, 0, 30);
      applyStimulus(0, 0, 0, 0);

      applyStimulus(3, 10, 40, 0);
      applyStimulus(0, 0, 0, 0);

      for (int r = 0; r < 6; r++) begin
         flipMask = NV'($urandom);
         applyStimulus(4, (r == 2) ? int'($urandom_range(1, 79)) : 0, 0, 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
